// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM encoding,
// blank pattern and the active-low hex glyph table ({g,f,e,d,c,b,a}).
package ssd_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 0 is the rightmost entry: glyphs F,E,d,C,b,A,9..0 from left to right.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nib];

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with anti-ghost blanking,
// double-buffered value/decimal-point registers and leading-zero suppression.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refresh_tick,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic        pending
);

  localparam logic [7:0] GUARD_RELOAD = 8'(GUARD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [7:0]  guard_q, guard_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  sdp_q, sdp_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  ddp_q, ddp_d;
  logic        pending_q, pending_d;
  logic        wrap_q, wrap_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic        commit;
  logic        upper_zero;
  logic [3:0]  sel_nib;
  logic [6:0]  glyph;

  assign sel_nib = 4'(disp_q >> {digit_q, 2'b00});

  hex_to_seg u_hex_to_seg (
    .nib (sel_nib),
    .seg (glyph)
  );

  // Next-state logic: scan sequencing, buffering and output decode
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    guard_d  = guard_q;
    wrap_d   = 1'b0;

    // A tick is never dropped: it always advances the digit and restarts blanking.
    if (refresh_tick) begin
      state_d = ST_BLANK;
      guard_d = GUARD_RELOAD;
      digit_d = digit_q + 2'd1;
      wrap_d  = (digit_q == 2'd3);
    end else if (state_q == ST_BLANK) begin
      if (guard_q == 8'd0) begin
        state_d = ST_SHOW;
      end else begin
        guard_d = guard_q - 8'd1;
      end
    end else begin
      state_d = ST_SHOW;
    end

    commit = wrap_d && pending_q;

    if (commit) begin
      disp_d = shadow_q;
      ddp_d  = sdp_q;
    end else begin
      disp_d = disp_q;
      ddp_d  = ddp_q;
    end

    // A load on the commit edge lands in the shadow and keeps pending set.
    if (load) begin
      shadow_d  = value;
      sdp_d     = dp_in;
      pending_d = 1'b1;
    end else begin
      shadow_d  = shadow_q;
      sdp_d     = sdp_q;
      pending_d = commit ? 1'b0 : pending_q;
    end

    case (digit_q)
      2'd1:    upper_zero = (disp_q[15:4] == 12'h000);
      2'd2:    upper_zero = (disp_q[15:8] == 8'h00);
      2'd3:    upper_zero = (disp_q[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase

    if (state_q == ST_SHOW) begin
      an_d = ~(4'b0001 << digit_q);
      if (lz_en && upper_zero) begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end else begin
        seg_d = glyph;
        dp_d  = ~ddp_q[digit_q];
      end
    end else begin
      an_d  = 4'hF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end

    frame_done_d = wrap_q;
  end

  // State, buffer and registered-output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      digit_q      <= 2'd0;
      guard_q      <= GUARD_RELOAD;
      shadow_q     <= 16'h0000;
      sdp_q        <= 4'h0;
      disp_q       <= 16'h0000;
      ddp_q        <= 4'h0;
      pending_q    <= 1'b0;
      wrap_q       <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      guard_q      <= guard_d;
      shadow_q     <= shadow_d;
      sdp_q        <= sdp_d;
      disp_q       <= disp_d;
      ddp_q        <= ddp_d;
      pending_q    <= pending_d;
      wrap_q       <= wrap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed self-checking bench for ssd_scan_driver with GUARD_CYCLES=4.
module tb_ssd_scan_driver;

  logic        clk;
  logic        reset;
  logic        refresh_tick;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic        pending;

  int n_checks = 0;
  int n_passed = 0;

  ssd_scan_driver #(.GUARD_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .value        (value),
    .load         (load),
    .dp_in        (dp_in),
    .lz_en        (lz_en),
    .an           (an),
    .seg          (seg),
    .dp           (dp),
    .frame_done   (frame_done),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_passed++;
  endtask

  // Count negedges until an anode asserts (bounded), tallying frame_done pulses.
  task automatic wait_show(output int n, output int fd);
    n  = 0;
    fd = 0;
    do begin
      @(negedge clk);
      n++;
      if (frame_done) fd++;
    end while (an == 4'hF && n < 20);
  endtask

  // One tick (optionally with a load on the same edge), then check the next shown digit.
  task automatic step(input string tag, input logic ld, input logic [15:0] v,
                      input logic [3:0] dpi, input logic [3:0] e_an, input logic [6:0] e_seg,
                      input logic e_dp, input logic e_fd, input logic e_pend);
    int n, fd;
    refresh_tick = 1'b1;
    load         = ld;
    value        = v;
    dp_in        = dpi;
    @(negedge clk);
    refresh_tick = 1'b0;
    load         = 1'b0;
    wait_show(n, fd);
    chk({tag, ".gap"},  32'(n), 32'd5);
    chk({tag, ".an"},   {28'd0, an},   {28'd0, e_an});
    chk({tag, ".seg"},  {25'd0, seg},  {25'd0, e_seg});
    chk({tag, ".dp"},   {31'd0, dp},   {31'd0, e_dp});
    chk({tag, ".fd"},   32'(fd),       {31'd0, e_fd});
    chk({tag, ".pend"}, {31'd0, pending}, {31'd0, e_pend});
  endtask

  initial begin
    int n, fd;
    reset        = 1'b1;
    refresh_tick = 1'b0;
    value        = 16'h0000;
    load         = 1'b0;
    dp_in        = 4'h0;
    lz_en        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.an",   {28'd0, an},  32'hF);
    chk("rst.seg",  {25'd0, seg}, 32'h7F);
    chk("rst.dp",   {31'd0, dp},  32'd1);
    chk("rst.fd",   {31'd0, frame_done}, 32'd0);
    chk("rst.pend", {31'd0, pending},    32'd0);

    // First digit appears after the guard interval with display 0.
    reset = 1'b0;
    wait_show(n, fd);
    chk("init.gap", 32'(n), 32'd5);
    chk("init.an",  {28'd0, an},  32'hE);
    chk("init.seg", {25'd0, seg}, 32'h40);
    chk("init.dp",  {31'd0, dp},  32'd1);

    // Load 12AF (dp on digit 1): first frame still shows zeros, then commit.
    step("f1d1", 1'b1, 16'h12AF, 4'b0010, 4'hD, 7'h40, 1'b1, 1'b0, 1'b1);
    step("f1d2", 1'b0, 16'h0000, 4'h0,    4'hB, 7'h40, 1'b1, 1'b0, 1'b1);
    step("f1d3", 1'b0, 16'h0000, 4'h0,    4'h7, 7'h40, 1'b1, 1'b0, 1'b1);
    step("f2d0", 1'b0, 16'h0000, 4'h0,    4'hE, 7'h0E, 1'b1, 1'b1, 1'b0);
    step("f2d1", 1'b0, 16'h0000, 4'h0,    4'hD, 7'h08, 1'b0, 1'b0, 1'b0);
    step("f2d2", 1'b0, 16'h0000, 4'h0,    4'hB, 7'h24, 1'b1, 1'b0, 1'b0);
    step("f2d3", 1'b0, 16'h0000, 4'h0,    4'h7, 7'h79, 1'b1, 1'b0, 1'b0);
    step("f3d0", 1'b0, 16'h0000, 4'h0,    4'hE, 7'h0E, 1'b1, 1'b1, 1'b0);

    // Shadow 1111, then load 2222 on the wrap edge itself.
    step("f3d1", 1'b1, 16'h1111, 4'h0,    4'hD, 7'h08, 1'b0, 1'b0, 1'b1);
    step("f3d2", 1'b0, 16'h0000, 4'h0,    4'hB, 7'h24, 1'b1, 1'b0, 1'b1);
    step("f3d3", 1'b0, 16'h0000, 4'h0,    4'h7, 7'h79, 1'b1, 1'b0, 1'b1);
    step("f4d0", 1'b1, 16'h2222, 4'h0,    4'hE, 7'h79, 1'b1, 1'b1, 1'b1);
    step("f4d1", 1'b0, 16'h0000, 4'h0,    4'hD, 7'h79, 1'b1, 1'b0, 1'b1);
    step("f4d2", 1'b0, 16'h0000, 4'h0,    4'hB, 7'h79, 1'b1, 1'b0, 1'b1);
    step("f4d3", 1'b0, 16'h0000, 4'h0,    4'h7, 7'h79, 1'b1, 1'b0, 1'b1);
    step("f5d0", 1'b0, 16'h0000, 4'h0,    4'hE, 7'h24, 1'b1, 1'b1, 1'b0);

    // Leading-zero suppression on 0007 with all dp requested.
    step("f5d1", 1'b1, 16'h0007, 4'hF,    4'hD, 7'h24, 1'b1, 1'b0, 1'b1);
    step("f5d2", 1'b0, 16'h0000, 4'h0,    4'hB, 7'h24, 1'b1, 1'b0, 1'b1);
    step("f5d3", 1'b0, 16'h0000, 4'h0,    4'h7, 7'h24, 1'b1, 1'b0, 1'b1);
    lz_en = 1'b1;
    step("lz_d0", 1'b0, 16'h0000, 4'h0,   4'hE, 7'h78, 1'b0, 1'b1, 1'b0);
    step("lz_d1", 1'b0, 16'h0000, 4'h0,   4'hD, 7'h7F, 1'b1, 1'b0, 1'b0);
    step("lz_d2", 1'b0, 16'h0000, 4'h0,   4'hB, 7'h7F, 1'b1, 1'b0, 1'b0);
    step("lz_d3", 1'b0, 16'h0000, 4'h0,   4'h7, 7'h7F, 1'b1, 1'b0, 1'b0);
    lz_en = 1'b0;
    step("nolz_d0", 1'b0, 16'h0000, 4'h0, 4'hE, 7'h78, 1'b0, 1'b1, 1'b0);
    step("nolz_d1", 1'b0, 16'h0000, 4'h0, 4'hD, 7'h40, 1'b0, 1'b0, 1'b0);

    // Tick during the second blank cycle: digit 2 skipped, guard restarts.
    refresh_tick = 1'b1;
    @(negedge clk);
    refresh_tick = 1'b0;
    @(negedge clk);
    chk("skip.blank", {28'd0, an}, 32'hF);
    refresh_tick = 1'b1;
    @(negedge clk);
    refresh_tick = 1'b0;
    wait_show(n, fd);
    chk("skip.gap", 32'(n), 32'd5);
    chk("skip.an",  {28'd0, an},  32'h7);
    chk("skip.seg", {25'd0, seg}, 32'h40);
    chk("skip.dp",  {31'd0, dp},  32'd0);

    // Reset during digit 2 with a pending load discards everything.
    step("pr_d0", 1'b1, 16'h5555, 4'h0, 4'hE, 7'h78, 1'b0, 1'b1, 1'b1);
    step("pr_d1", 1'b0, 16'h0000, 4'h0, 4'hD, 7'h40, 1'b0, 1'b0, 1'b1);
    step("pr_d2", 1'b0, 16'h0000, 4'h0, 4'hB, 7'h40, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst.an",   {28'd0, an},  32'hF);
    chk("mrst.seg",  {25'd0, seg}, 32'h7F);
    chk("mrst.dp",   {31'd0, dp},  32'd1);
    chk("mrst.fd",   {31'd0, frame_done}, 32'd0);
    chk("mrst.pend", {31'd0, pending},    32'd0);
    reset = 1'b0;
    wait_show(n, fd);
    chk("post.gap", 32'(n), 32'd5);
    chk("post.an",  {28'd0, an},  32'hE);
    chk("post.seg", {25'd0, seg}, 32'h40);
    step("post_d1", 1'b0, 16'h0000, 4'h0, 4'hD, 7'h40, 1'b1, 1'b0, 1'b0);
    step("post_d2", 1'b0, 16'h0000, 4'h0, 4'hB, 7'h40, 1'b1, 1'b0, 1'b0);
    step("post_d3", 1'b0, 16'h0000, 4'h0, 4'h7, 7'h40, 1'b1, 1'b0, 1'b0);
    step("post_w",  1'b0, 16'h0000, 4'h0, 4'hE, 7'h40, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
